// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780-class character-LCD controller with an 8-bit bus.
// Runs the power-on init sequence, then writes characters received on a
// valid/ready stream at an auto-advancing cursor with row wrap. Busy flag
// is polled over a split bidirectional bus; the pad tristate lives above.
//
// Optional feature macro: LCD_BF_TIMEOUT_EN
//   defined   - busy-flag polling gives up after BF_TIMEOUT reads and sets
//               the sticky timeout_err flag.
//   undefined - polling never ends; timeout_err is tied to 0.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   in_valid/in_data/in_ready   character stream input
//   clr_req         level request: clear display and home the cursor
//   init_done       init sequence finished (sticky until reset)
//   col, row        current cursor position
//   RS, RW, E       LCD control pins
//   DB_o/DB_i/DB_oe split data bus; only DB_i[7] (busy flag) is used
//   timeout_err     sticky busy-flag timeout
module lcd_char_ctrl #(
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned PWRON_CYC  = 108120,
    parameter int unsigned WAIT2_CYC  = 29560,
    parameter int unsigned WAIT3_CYC  = 740,
    parameter int unsigned BF_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       clr_req,
    output logic       init_done,
    output logic [5:0] col,
    output logic [1:0] row,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] DB_o,
    input  logic [7:0] DB_i,
    output logic       DB_oe,
    output logic       timeout_err
);

    localparam int unsigned PW = $clog2(CLK_DIV) + 1;
    localparam int unsigned WW = 24;

    localparam logic [7:0] CMD_FNSET = (ROWS > 1) ? 8'h38 : 8'h30;
    localparam logic [7:0] CMD_DPON  = 8'h0C;
    localparam logic [7:0] CMD_DPCLR = 8'h01;
    localparam logic [7:0] CMD_EMSET = 8'h06;
    localparam logic [7:0] CMD_WAKE  = 8'h30;

    // Main FSM states
    localparam logic [2:0] S_PWR  = 3'd0;
    localparam logic [2:0] S_W2   = 3'd1;
    localparam logic [2:0] S_W3   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_IDLE = 3'd5;

    // Which command the current bus transaction belongs to
    localparam logic [3:0] T_INIT0 = 4'd0;
    localparam logic [3:0] T_INIT1 = 4'd1;
    localparam logic [3:0] T_INIT2 = 4'd2;
    localparam logic [3:0] T_INIT3 = 4'd3;
    localparam logic [3:0] T_INIT4 = 4'd4;
    localparam logic [3:0] T_INIT5 = 4'd5;
    localparam logic [3:0] T_INIT6 = 4'd6;
    localparam logic [3:0] T_CHAR  = 4'd7;
    localparam logic [3:0] T_ADDR  = 4'd8;
    localparam logic [3:0] T_CLR   = 4'd9;

    // DDRAM row start addresses
    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'h14;
            default: row_base = 8'h54;
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [PW-1:0] div_q, div_d;
    logic [1:0]    ph_q, ph_d;
    logic          bf_q, bf_d;
    logic [5:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic          init_done_q, init_done_d;
    logic          rs_q, rs_d;
    logic          rw_q, rw_d;
    logic          e_q, e_d;
    logic [7:0]    db_q, db_d;
    logic          oe_q, oe_d;

    logic          last_clk;
    logic          cyc_end;
    logic          bf_expired;
    logic          launch;
    logic [3:0]    launch_step;
    logic [7:0]    launch_data;

    logic          unused_db;
    assign unused_db = ^DB_i[6:0];

    // Bus-cycle phase timing shared by write and read cycles
    assign last_clk = (div_q == PW'(CLK_DIV - 1));
    assign cyc_end  = last_clk && (ph_q == 2'd3);

`ifdef LCD_BF_TIMEOUT_EN
    localparam int unsigned PLW = $clog2(BF_TIMEOUT + 1);

    logic [PLW-1:0] poll_q, poll_d;
    logic           timeout_q, timeout_d;

    assign bf_expired = bf_q && (poll_q == PLW'(BF_TIMEOUT - 1));

    // Poll counter restarts at the first read of every poll; error is sticky
    always_comb begin
        poll_d    = poll_q;
        timeout_d = timeout_q;
        if (state_q == S_WR && state_d == S_RD) begin
            poll_d = '0;
        end else if (state_q == S_RD && cyc_end) begin
            poll_d = poll_q + 1'b1;
            if (bf_expired) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            poll_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            poll_q    <= poll_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    localparam int unsigned UNUSED_BF_TIMEOUT = BF_TIMEOUT;

    assign bf_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and bus-output logic
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        wait_d      = wait_q;
        div_d       = div_q;
        ph_d        = ph_q;
        bf_d        = bf_q;
        col_d       = col_q;
        row_d       = row_q;
        init_done_d = init_done_q;
        db_d        = db_q;
        launch      = 1'b0;
        launch_step = step_q;
        launch_data = db_q;

        if (state_q == S_WR || state_q == S_RD) begin
            if (last_clk) begin
                div_d = '0;
                ph_d  = ph_q + 2'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        case (state_q)
            S_PWR, S_W2, S_W3: begin
                wait_d = wait_q + 1'b1;
                if ((state_q == S_PWR && wait_q == WW'(PWRON_CYC - 1)) ||
                    (state_q == S_W2  && wait_q == WW'(WAIT2_CYC - 1)) ||
                    (state_q == S_W3  && wait_q == WW'(WAIT3_CYC - 1))) begin
                    launch      = 1'b1;
                    launch_data = CMD_WAKE;
                    launch_step = (state_q == S_PWR) ? T_INIT0 :
                                  (state_q == S_W2)  ? T_INIT1 : T_INIT2;
                end
            end

            S_WR: begin
                if (cyc_end) begin
                    case (step_q)
                        T_INIT0: begin
                            state_d = S_W2;
                            wait_d  = '0;
                        end
                        T_INIT1: begin
                            state_d = S_W3;
                            wait_d  = '0;
                        end
                        // BF is not valid yet after the last wake-up write
                        T_INIT2: begin
                            launch      = 1'b1;
                            launch_step = T_INIT3;
                            launch_data = CMD_FNSET;
                        end
                        default: begin
                            state_d = S_RD;
                            bf_d    = 1'b0;
                        end
                    endcase
                end
            end

            S_RD: begin
                if (ph_q == 2'd2 && last_clk) begin
                    bf_d = DB_i[7];
                end
                // bf_q holds this cycle's sample once P3 is reached
                if (cyc_end && (!bf_q || bf_expired)) begin
                    case (step_q)
                        T_INIT3: begin
                            launch      = 1'b1;
                            launch_step = T_INIT4;
                            launch_data = CMD_DPON;
                        end
                        T_INIT4: begin
                            launch      = 1'b1;
                            launch_step = T_INIT5;
                            launch_data = CMD_DPCLR;
                        end
                        T_INIT5: begin
                            launch      = 1'b1;
                            launch_step = T_INIT6;
                            launch_data = CMD_EMSET;
                        end
                        T_CHAR: begin
                            if (col_q == 6'(COLS - 1)) begin
                                col_d       = '0;
                                row_d       = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
                                launch      = 1'b1;
                                launch_step = T_ADDR;
                                launch_data = 8'h80 | row_base(row_d);
                            end else begin
                                col_d   = col_q + 6'd1;
                                state_d = S_IDLE;
                            end
                        end
                        T_CLR: begin
                            col_d   = '0;
                            row_d   = '0;
                            state_d = S_IDLE;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end

            S_IDLE: begin
                if (clr_req) begin
                    launch      = 1'b1;
                    launch_step = T_CLR;
                    launch_data = CMD_DPCLR;
                end else if (in_valid) begin
                    launch      = 1'b1;
                    launch_step = T_CHAR;
                    launch_data = in_data;
                end
            end

            default: begin
                state_d = S_PWR;
                wait_d  = '0;
            end
        endcase

        if (launch) begin
            state_d = S_WR;
            step_d  = launch_step;
            db_d    = launch_data;
            ph_d    = 2'd0;
            div_d   = '0;
        end

        if (state_d == S_IDLE) begin
            init_done_d = 1'b1;
        end

        // Pins follow the next state so they register in step with it
        rw_d = (state_d == S_RD);
        oe_d = !rw_d;
        rs_d = (state_d == S_WR) && (step_d == T_CHAR);
        e_d  = ((state_d == S_WR) || (state_d == S_RD)) &&
               ((ph_d == 2'd1) || (ph_d == 2'd2));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_PWR;
            step_q      <= T_INIT0;
            wait_q      <= '0;
            div_q       <= '0;
            ph_q        <= '0;
            bf_q        <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            e_q         <= 1'b0;
            db_q        <= '0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            wait_q      <= wait_d;
            div_q       <= div_d;
            ph_q        <= ph_d;
            bf_q        <= bf_d;
            col_q       <= col_d;
            row_q       <= row_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            e_q         <= e_d;
            db_q        <= db_d;
            oe_q        <= oe_d;
        end
    end

    // clr_req has priority, so it masks readiness in the same cycle
    assign in_ready  = (state_q == S_IDLE) && !clr_req;
    assign init_done = init_done_q;
    assign col       = col_q;
    assign row       = row_q;
    assign RS        = rs_q;
    assign RW        = rw_q;
    assign E         = e_q;
    assign DB_o      = db_q;
    assign DB_oe     = oe_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: directed, table-driven bench for lcd_char_ctrl with a
// small LCD model that reports busy for a programmable number of reads.
module tb_lcd_char_ctrl;

    localparam int unsigned COLS = 4;
    localparam int unsigned ROWS = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       clr_req;
    logic       init_done;
    logic [5:0] col;
    logic [1:0] row;
    logic       RS, RW, E;
    logic [7:0] DB_o;
    logic [7:0] DB_i;
    logic       DB_oe;
    logic       timeout_err;

    lcd_char_ctrl #(
        .CLK_DIV(1), .COLS(COLS), .ROWS(ROWS),
        .PWRON_CYC(40), .WAIT2_CYC(12), .WAIT3_CYC(4), .BF_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clr_req(clr_req), .init_done(init_done),
        .col(col), .row(row),
        .RS(RS), .RW(RW), .E(E),
        .DB_o(DB_o), .DB_i(DB_i), .DB_oe(DB_oe),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
        logic       oe;
    } wr_t;

    typedef struct {
        logic [7:0] ch;
        int         nbusy;
        int         ecol;
        int         erow;
        logic       has_addr;
        logic [7:0] eaddr;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   first_rise = -1;
    int   n_reads = 0;
    int   rd_bad = 0;
    int   reads_at_to = -1;
    int   n_busy = 0;
    int   busy = 0;
    logic stuck = 1'b0;
    logic e_prev = 1'b0;
    logic rw_prev = 1'b0;
    wr_t  wq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign DB_i = {(stuck || busy > 0), 7'b0};

    // LCD model: logs writes and reads, counts down busy on each read
    always @(negedge clk) begin
        if (!rst) begin
            busy   = 0;
            e_prev = 1'b0;
        end else begin
            if (E && !e_prev) begin
                if (!RW) begin
                    wq.push_back({RS, DB_o, DB_oe});
                    if (first_rise < 0) first_rise = cyc - rel_cyc;
                end else begin
                    n_reads++;
                    if (DB_oe !== 1'b0 || RS !== 1'b0) rd_bad++;
                end
            end
            if (!E && e_prev) begin
                if (!rw_prev) busy = n_busy;
                else if (busy > 0) busy--;
            end
            if (timeout_err && reads_at_to < 0) reads_at_to = n_reads;
            e_prev  = E;
            rw_prev = RW;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wq.delete();
        n_reads     = 0;
        rd_bad      = 0;
        first_rise  = -1;
        reads_at_to = -1;
    endtask

    task automatic release_reset();
        rel_cyc = cyc;
        rst     = 1'b1;
    endtask

    // Wait at negedges for in_ready (or init_done), bounded
    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready && init_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 32'(n), 32'(0));
        #1;
    endtask

    // Release reset and check the full init sequence
    task automatic run_init(input string tag);
        logic [7:0] init_exp [7];
        init_exp = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
        release_reset();
        wait_ready({tag, "_init"}, 600);
        chk({tag, "_first_e_clk"}, 32'(first_rise), 32'(41));
        chk({tag, "_init_writes"}, 32'(wq.size()), 32'(7));
        for (int i = 0; i < 7; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_init_cmd%0d", tag, i), 32'({wq[i].rs, wq[i].d, wq[i].oe}),
                    32'({1'b0, init_exp[i], 1'b1}));
            end
        end
        chk({tag, "_init_done"}, 32'(init_done), 32'(1));
        chk({tag, "_col0"}, 32'(col), 32'(0));
        chk({tag, "_row0"}, 32'(row), 32'(0));
        chk({tag, "_rd_pins"}, 32'(rd_bad), 32'(0));
        wq.delete();
    endtask

    // Present one character, check in_ready drops after accept
    task automatic send_char(input logic [7:0] ch);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = ch;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ready_low_after_accept", 32'(in_ready), 32'(0));
    endtask

    vec_t vecs [9];

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_req  = 1'b0;

        vecs[0] = '{8'h41, 3, 1, 0, 1'b0, 8'h00};
        vecs[1] = '{8'h42, 0, 2, 0, 1'b0, 8'h00};
        vecs[2] = '{8'h43, 1, 3, 0, 1'b0, 8'h00};
        vecs[3] = '{8'h44, 0, 0, 1, 1'b1, 8'hC0};
        vecs[4] = '{8'h45, 2, 1, 1, 1'b0, 8'h00};
        vecs[5] = '{8'h46, 0, 2, 1, 1'b0, 8'h00};
        vecs[6] = '{8'h47, 0, 3, 1, 1'b0, 8'h00};
        vecs[7] = '{8'h48, 1, 0, 0, 1'b1, 8'h80};
        vecs[8] = '{8'h49, 0, 1, 0, 1'b0, 8'h00};

        // Reset state
        apply_reset();
        chk("rst_E", 32'(E), 32'(0));
        chk("rst_init_done", 32'(init_done), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_DB_oe", 32'(DB_oe), 32'(0));

        // Power-on init
        n_busy = 0;
        run_init("t1");

        // Character writes, wraps and address commands
        for (int v = 0; v < 9; v++) begin
            n_busy  = vecs[v].nbusy;
            n_reads = 0;
            wq.delete();
            send_char(vecs[v].ch);
            wait_ready($sformatf("v%0d", v), 200);
            chk($sformatf("v%0d_nwr", v), 32'(wq.size()), 32'(vecs[v].has_addr ? 2 : 1));
            if (wq.size() > 0)
                chk($sformatf("v%0d_char", v), 32'({wq[0].rs, wq[0].d, wq[0].oe}),
                    32'({1'b1, vecs[v].ch, 1'b1}));
            if (vecs[v].has_addr && wq.size() > 1)
                chk($sformatf("v%0d_addr", v), 32'({wq[1].rs, wq[1].d}),
                    32'({1'b0, vecs[v].eaddr}));
            if (!vecs[v].has_addr)
                chk($sformatf("v%0d_reads", v), 32'(n_reads), 32'(vecs[v].nbusy + 1));
            chk($sformatf("v%0d_col", v), 32'(col), 32'(vecs[v].ecol));
            chk($sformatf("v%0d_row", v), 32'(row), 32'(vecs[v].erow));
        end
        chk("t2_rd_pins", 32'(rd_bad), 32'(0));

        // clr_req wins over in_valid in the same idle cycle
        n_busy = 1;
        wq.delete();
        @(negedge clk);
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        chk("t4_ready_masked", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("t4_clr_timeout", 32'(n), 32'(0));
            chk("t4_col_cleared", 32'(col), 32'(0));
            chk("t4_row_cleared", 32'(row), 32'(0));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        wait_ready("t4_char", 200);
        chk("t4_nwr", 32'(wq.size()), 32'(2));
        if (wq.size() > 1) begin
            chk("t4_clr_cmd", 32'({wq[0].rs, wq[0].d}), 32'({1'b0, 8'h01}));
            chk("t4_char", 32'({wq[1].rs, wq[1].d}), 32'({1'b1, 8'h5A}));
        end
        chk("t4_col", 32'(col), 32'(1));

        // Reset in the middle of a write with E high
        n_busy = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h33;
        begin
            int n;
            n = 0;
            @(negedge clk);
            in_valid = 1'b0;
            while (!E && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("t5_e_timeout", 32'(n), 32'(0));
        end
        chk("t5_e_high", 32'(E), 32'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_E", 32'(E), 32'(0));
        chk("t5_in_ready", 32'(in_ready), 32'(0));
        chk("t5_init_done", 32'(init_done), 32'(0));
        chk("t5_col", 32'(col), 32'(0));
        apply_reset();
        run_init("t5");

        // Busy flag stuck high
        apply_reset();
        stuck = 1'b1;
        release_reset();
`ifdef LCD_BF_TIMEOUT_EN
        wait_ready("t6_to", 2000);
        chk("t6_timeout_err", 32'(timeout_err), 32'(1));
        chk("t6_reads_at_to", 32'(reads_at_to), 32'(8));
        chk("t6_init_writes", 32'(wq.size()), 32'(7));
`else
        repeat (400) @(negedge clk);
        chk("t6_init_done", 32'(init_done), 32'(0));
        chk("t6_timeout_err", 32'(timeout_err), 32'(0));
        chk("t6_polling", 32'(n_reads >= 50), 32'(1));
        chk("t6_init_writes", 32'(wq.size()), 32'(4));
`endif
        stuck = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
